rmap_header_parser: RTL
=======================

# rmap_header_parser

Sits directly downstream of the SpaceWire receive FIFO in the RMAP target and pops 9-bit characters from it. Parses each RMAP command header field by field and checks the header CRC-8. Presents the decoded header to the command executor on a valid/ready handshake, then forwards the rest of the packet (data field plus end marker) as a byte stream. Malformed or foreign packets are flushed up to their end marker so the next packet starts clean.

## Interface
- TARGET_LA, 8'hFE: logical address this target answers to.
- CHECK_LA, 1: 1 = packets whose first byte ≠ TARGET_LA are silently discarded; 0 = any address is accepted.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- readEnable  out  1  pops the FIFO head; asserted only when empty=0.
- dataOut  in  9  FIFO head, first-word-fall-through. Bit 8 = control; with bit 8 set, [7:0]=0x00 is EOP and 0x01 is EEP.
- empty  in  1  FIFO empty.
- hdrValid / hdrReady  out/in  1/1  decoded-header handshake.
- instruction, key, initiatorLA, extAddr  out  8 each  header fields.
- transId  out  16  transaction ID.
- address  out  32  memory address.
- dataLength  out  24  data length.
- replyAddr  out  96  reply address, right-aligned.
- replyAddrLen  out  4  reply address length: 0, 4, 8 or 12 bytes.
- bodyData / bodyValid / bodyReady  out/out/in  9/1/1  post-header stream.
- errValid  out  1  one-cycle pulse reporting a header error.
- errCode  out  3  error code: 1 CRC, 2 protocol ID ≠ 0x01, 3 packet type ≠ command, 4 early EOP/EEP.

## Operation
- States:
  - IDLE: waiting for the first byte of a packet.
  - HDR: collecting header bytes.
  - HDR_OUT: presenting the decoded header.
  - BODY: forwarding the packet remainder.
  - DISCARD: flushing to the end marker.
- IDLE:
  - EOP/EEP at the head: popped and ignored (empty packet); no error is raised.
  - Data byte: popped and compared with TARGET_LA. On mismatch with CHECK_LA=1, go to DISCARD with no error. Otherwise go to HDR.
- HDR: byte counter steps through the fields in this order:
  - protocol ID
  - instruction
  - key
  - reply address (replyAddrLen bytes, where replyAddrLen = 4·instruction[1:0])
  - initiatorLA
  - transId (2 bytes, MSB first)
  - extAddr
  - address (4 bytes, MSB first)
  - dataLength (3 bytes, MSB first)
  - header CRC
- Field checks:
  - Protocol ID is checked when received → errCode 2.
  - instruction[7:6]≠2'b01 is checked when received → errCode 3.
  - EOP/EEP anywhere in HDR → errCode 4. The marker is consumed and the parser returns to IDLE.
- Every error except code 4 goes to DISCARD. DISCARD pops words through and including the next EOP/EEP, then returns to IDLE.
- CRC:
  - RMAP CRC-8 (ECSS-E-ST-50-52C table/bitwise equivalent), initial value 0x00.
  - Runs over every header byte starting at the target LA, including the CRC byte.
  - Final value ≠ 0x00 → errCode 1.
- HDR_OUT: hdrValid=1 and all field outputs are held stable until hdrReady=1. readEnable=0 throughout. Then go to BODY.
- BODY:
  - bodyValid = !empty, bodyData = dataOut, readEnable = bodyValid & bodyReady.
  - Popping EOP/EEP returns to IDLE.
  - Read commands normally produce only the EOP. Length and data-CRC checks belong to the executor.

## Timing
- At most one FIFO pop per cycle. In IDLE/HDR/DISCARD, readEnable = !empty.
- hdrValid rises the cycle after the CRC byte is popped. Header latency = header bytes + 1 cycle with a non-empty FIFO.
- errValid pulses the cycle after the offending byte is popped. errCode holds its value until the next error.
- The BODY path is combinational (zero latency). bodyData is only meaningful while bodyValid=1.
- The hdrValid/hdrReady transfer completes in the cycle where both are 1. BODY begins the next cycle.
- Reset values:
  - All outputs 0, state IDLE, CRC 0x00.
  - Reset mid-packet abandons the packet. The next FIFO word after reset is treated as a packet start, with no resynchronisation.

## Configuration
- RMAP_PARSER_STATS_EN defined: three 16-bit saturating counters, readable as outputs statPkts, statCrcErr and statDiscard, all reset to 0.
  - statPkts increments on every completed header handshake.
  - statCrcErr increments on every errCode 1.
  - statDiscard increments on every entry to DISCARD.
- Undefined: the counters and their ports are absent.

## Structure
- rmap_pkg holds:
  - the state enum
  - the errCode localparams
  - the PROTOCOL_ID=8'h01 constant
  - the EOP/EEP 9-bit constants
  - the function crc8_step(crc, byte)
- Sub-module rmap_crc8: running CRC register with clear/enable inputs; uses crc8_step.

## Test plan
- Write command to LA 0xFE, 0-byte reply address, valid CRC, 4 data bytes + EOP:
  - Header decodes with address=0x00001000, dataLength=4.
  - 5 words follow on the body stream.
- Same header with the CRC byte XOR 0x01 → errValid with errCode=1; no hdrValid; FIFO drained through EOP.
- instruction=0x4A (reply address length 8, 8-byte reply address 00…0A0B) → replyAddrLen=8, replyAddr[63:0]=0x000000000000_0A0B.
- EEP after 5 header bytes → errCode=4; the following valid packet parses correctly.
- First byte 0x20 with CHECK_LA=1 → no error and no hdrValid; the next packet to 0xFE parses normally.
- hdrReady held low for 10 cycles → fields stable, readEnable=0 in every one of those cycles; accepted on the 11th cycle.

Source files
------------

// File: rtl/rmap_pkg.sv
// Shared types and helpers for the RMAP command-header parser.
// Optional statistics counters in the top are enabled with RMAP_PARSER_STATS_EN.
package rmap_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HDR_OUT,
        S_BODY,
        S_DISCARD
    } state_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_CRC       = 3'd1;
    localparam logic [2:0] ERR_PROTO     = 3'd2;
    localparam logic [2:0] ERR_TYPE      = 3'd3;
    localparam logic [2:0] ERR_EARLY_EOP = 3'd4;

    localparam logic [7:0] PROTOCOL_ID = 8'h01;
    localparam logic [8:0] EOP_CHAR    = 9'h100;
    localparam logic [8:0] EEP_CHAR    = 9'h101;

    // Reflected CRC-8 (x^8+x^2+x+1), bits consumed LSB first as on the link.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 8'hE0) : (c >> 1);
        return c;
    endfunction

    function automatic logic is_marker(input logic [8:0] w);
        return (w == EOP_CHAR) || (w == EEP_CHAR);
    endfunction

endpackage

// File: rtl/rmap_crc8.sv
// Running RMAP header CRC-8; crc_nxt is the value after absorbing din this cycle.
module rmap_crc8
    import rmap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc_nxt
);
    logic [7:0] crc;

    // A clear and an enable together start a fresh CRC with din as first byte.
    assign crc_nxt = crc8_step(clr ? 8'h00 : crc, din);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   crc <= 8'h00;
        else if (en)  crc <= crc_nxt;
        else if (clr) crc <= 8'h00;
    end
endmodule

// File: rtl/rmap_header_parser.sv
// RMAP command-header parser: decodes header fields, checks header CRC, streams the body.
// Define RMAP_PARSER_STATS_EN to add the statPkts/statCrcErr/statDiscard counters.
module rmap_header_parser
    import rmap_pkg::*;
#(
    parameter logic [7:0] TARGET_LA = 8'hFE,
    parameter bit         CHECK_LA  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        readEnable,
    input  logic [8:0]  dataOut,
    input  logic        empty,
    output logic        hdrValid,
    input  logic        hdrReady,
    output logic [7:0]  instruction,
    output logic [7:0]  key,
    output logic [7:0]  initiatorLA,
    output logic [7:0]  extAddr,
    output logic [15:0] transId,
    output logic [31:0] address,
    output logic [23:0] dataLength,
    output logic [95:0] replyAddr,
    output logic [3:0]  replyAddrLen,
    output logic [8:0]  bodyData,
    output logic        bodyValid,
    input  logic        bodyReady,
    output logic        errValid,
`ifdef RMAP_PARSER_STATS_EN
    output logic [15:0] statPkts,
    output logic [15:0] statCrcErr,
    output logic [15:0] statDiscard,
`endif
    output logic [2:0]  errCode
);
    state_t     state, state_nxt;
    logic [4:0] cnt;
    logic [4:0] rel;
    logic [3:0] rl;
    logic       in_reply, crc_pos, mark;
    logic       crc_clr, crc_en, err_set;
    logic [2:0] err_code_nxt;
    logic [7:0] crc_nxt;
    logic [7:0] b;

    assign b            = dataOut[7:0];
    assign mark         = is_marker(dataOut);
    assign rl           = {instruction[1:0], 2'b00};
    assign replyAddrLen = rl;
    // cnt counts bytes after the logical address; rel indexes the fixed tail after the reply address.
    assign rel      = cnt - 5'd3 - {1'b0, rl};
    assign in_reply = (cnt >= 5'd3) && (cnt < 5'd3 + {1'b0, rl});
    assign crc_pos  = (cnt >= 5'd3) && !in_reply && (rel == 5'd11);

    rmap_crc8 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .din    (b),
        .crc_nxt(crc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        readEnable   = 1'b0;
        hdrValid     = 1'b0;
        bodyValid    = 1'b0;
        bodyData     = '0;
        err_set      = 1'b0;
        err_code_nxt = ERR_NONE;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;
        case (state)
            S_IDLE: begin
                readEnable = !empty;
                crc_clr    = 1'b1;
                if (!empty && !mark) begin
                    crc_en = 1'b1;
                    if (CHECK_LA && (b != TARGET_LA)) state_nxt = S_DISCARD;
                    else                              state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                readEnable = !empty;
                if (!empty) begin
                    if (mark) begin
                        err_set      = 1'b1;
                        err_code_nxt = ERR_EARLY_EOP;
                        state_nxt    = S_IDLE;
                    end else begin
                        crc_en = 1'b1;
                        if (cnt == 5'd0 && b != PROTOCOL_ID) begin
                            err_set      = 1'b1;
                            err_code_nxt = ERR_PROTO;
                            state_nxt    = S_DISCARD;
                        end else if (cnt == 5'd1 && b[7:6] != 2'b01) begin
                            err_set      = 1'b1;
                            err_code_nxt = ERR_TYPE;
                            state_nxt    = S_DISCARD;
                        end else if (crc_pos) begin
                            if (crc_nxt != 8'h00) begin
                                err_set      = 1'b1;
                                err_code_nxt = ERR_CRC;
                                state_nxt    = S_DISCARD;
                            end else begin
                                state_nxt = S_HDR_OUT;
                            end
                        end
                    end
                end
            end
            S_HDR_OUT: begin
                hdrValid = 1'b1;
                if (hdrReady) state_nxt = S_BODY;
            end
            S_BODY: begin
                bodyValid  = !empty;
                bodyData   = dataOut;
                readEnable = bodyValid && bodyReady;
                if (readEnable && mark) state_nxt = S_IDLE;
            end
            S_DISCARD: begin
                readEnable = !empty;
                if (!empty && mark) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            instruction <= '0;
            key         <= '0;
            initiatorLA <= '0;
            extAddr     <= '0;
            transId     <= '0;
            address     <= '0;
            dataLength  <= '0;
            replyAddr   <= '0;
            errValid    <= 1'b0;
            errCode     <= '0;
        end else begin
            errValid <= err_set;
            if (err_set) errCode <= err_code_nxt;
            // Multi-byte fields shift in MSB first, so they must start from zero.
            if (state == S_IDLE && state_nxt == S_HDR) begin
                cnt         <= '0;
                instruction <= '0;
                key         <= '0;
                initiatorLA <= '0;
                extAddr     <= '0;
                transId     <= '0;
                address     <= '0;
                dataLength  <= '0;
                replyAddr   <= '0;
            end else if (state == S_HDR && readEnable && !mark) begin
                cnt <= cnt + 5'd1;
                if (cnt == 5'd1)      instruction <= b;
                else if (cnt == 5'd2) key <= b;
                else if (in_reply)    replyAddr <= {replyAddr[87:0], b};
                else if (cnt >= 5'd3) begin
                    case (rel)
                        5'd0:                    initiatorLA <= b;
                        5'd1, 5'd2:              transId     <= {transId[7:0], b};
                        5'd3:                    extAddr     <= b;
                        5'd4, 5'd5, 5'd6, 5'd7:  address     <= {address[23:0], b};
                        5'd8, 5'd9, 5'd10:       dataLength  <= {dataLength[15:0], b};
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef RMAP_PARSER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statPkts    <= '0;
            statCrcErr  <= '0;
            statDiscard <= '0;
        end else begin
            if (state == S_HDR_OUT && hdrReady && statPkts != 16'hFFFF)
                statPkts <= statPkts + 16'd1;
            if (err_set && err_code_nxt == ERR_CRC && statCrcErr != 16'hFFFF)
                statCrcErr <= statCrcErr + 16'd1;
            if (state_nxt == S_DISCARD && state != S_DISCARD && statDiscard != 16'hFFFF)
                statDiscard <= statDiscard + 16'd1;
        end
    end
`endif
endmodule
